// File: rtl/ppm_pkg.sv
// Shared VLC 4-PPM line constants, error codes and state encodings used by
// both the transmit encoder and the receive decoder.
package ppm_pkg;

    localparam int SLOT_CLKS   = 16;
    localparam int SYMBOL_CLKS = 128;
    localparam int SOF_GAP     = 80;
    localparam int DATA_START  = 128;
    localparam int EOF_START   = 640;
    localparam int EOF_FALL    = 672;
    localparam int FRAME_END   = 704;

    localparam int FC_W  = 10;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_SOF  = 2'b01,
        ERR_SYM  = 2'b10,
        ERR_EOF  = 2'b11
    } err_e;

    // Field order the encoder walks through for one frame.
    typedef enum logic [1:0] {
        ORD_SOF  = 2'd0,
        ORD_DATA = 2'd1,
        ORD_EOF  = 2'd2,
        ORD_IDLE = 2'd3
    } ord_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SOF2 = 2'd1,
        ST_DATA = 2'd2,
        ST_EOF  = 2'd3
    } dec_state_e;

    function automatic logic in_win(input int val, input int center, input int tol);
        return (val >= center - tol) && (val <= center + tol);
    endfunction

endpackage

// File: rtl/ppm_line_sync.sv
// Line synchroniser: flop chain on din, registered fall/rise detect and a
// saturating low-time counter that reads N on the cycle a pulse N wide rises.
module ppm_line_sync
    import ppm_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CW          = CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din,
    output logic          fe,
    output logic          re,
    output logic [CW-1:0] low_cnt
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   line;
    logic                   line_q;

    assign line = chain[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain   <= '1;
            line_q  <= 1'b1;
            fe      <= 1'b0;
            re      <= 1'b0;
            low_cnt <= '0;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
            line_q <= line;
            fe     <= line_q & ~line;
            re     <= ~line_q & line;
            // Zero lines up with the fe strobe; counting stops once the line is high.
            if (line_q & ~line)
                low_cnt <= '0;
            else if (!line_q && low_cnt != '1)
                low_cnt <= low_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ppm_decoder.sv
// Receive-side 4-PPM frame decoder: SOF pair, four 2-bit symbols, EOF,
// with edge-position and pulse-width checks and typed frame errors.
module ppm_decoder
    import ppm_pkg::*;
#(
    parameter int TOL         = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam logic [FC_W-1:0]  FC_SOF_LATE = FC_W'(SOF_GAP + TOL);
    localparam logic [FC_W-1:0]  FC_SOF_NEXT = FC_W'(SOF_GAP + 1);
    localparam logic [FC_W-1:0]  FC_DATA     = FC_W'(DATA_START);
    localparam logic [FC_W-1:0]  FC_LAST     = FC_W'(FRAME_END - 1);
    localparam logic [CNT_W-1:0] LOW_MAX     = CNT_W'(SLOT_CLKS + TOL + 1);

    logic             fe;
    logic             re;
    logic [CNT_W-1:0] low_cnt;

    dec_state_e      state;
    logic [FC_W-1:0] fc;
    logic [6:0]      o;
    logic [1:0]      k;
    logic            got;
    logic            pend;
    err_e            pend_code;
    logic [7:0]      shreg;
    logic            sym_area;
    logic            sym_end;
    logic            err;
    err_e            code;

    ppm_line_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .CW         (CNT_W)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .fe     (fe),
        .re     (re),
        .low_cnt(low_cnt)
    );

    // fc[9:7] runs 1..4 over the data symbols, so k wraps to 0..3.
    assign o        = fc[6:0];
    assign k        = fc[8:7] - 2'd1;
    assign sym_area = (fc >= FC_DATA);
    assign sym_end  = sym_area && (o == 7'd127);

    always_comb begin
        err  = 1'b0;
        code = ERR_NONE;
        case (state)
            ST_SOF2: begin
                if (fe && !in_win(int'(fc), SOF_GAP, TOL)) begin
                    err = 1'b1; code = ERR_SOF;
                end else if (!fe && fc == FC_SOF_LATE) begin
                    err = 1'b1; code = ERR_SOF;
                end
            end
            ST_DATA: begin
                if (fe && (!sym_area || got || !in_win(int'(o[4:0]), SLOT_CLKS, TOL))) begin
                    err = 1'b1; code = ERR_SYM;
                end else if (sym_end && !got) begin
                    err = 1'b1; code = ERR_SYM;
                end
            end
            ST_EOF: begin
                if (fe && (got || !in_win(int'(fc), EOF_FALL, TOL))) begin
                    err = 1'b1; code = ERR_EOF;
                end else if (fc == FC_LAST && !got) begin
                    err = 1'b1; code = ERR_EOF;
                end
            end
            default: ;
        endcase
        // Width of the last accepted pulse is charged to the field that accepted it.
        if (state != ST_IDLE && pend &&
            ((re && !in_win(int'(low_cnt), SLOT_CLKS, TOL)) || (!re && low_cnt >= LOW_MAX))) begin
            err  = 1'b1;
            code = pend_code;
        end
    end

    // "fc = N at an edge" means the edge cycle is N, so the register loads N+1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            fc         <= '0;
            got        <= 1'b0;
            pend       <= 1'b0;
            pend_code  <= ERR_NONE;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (re) pend <= 1'b0;
            if (err) begin
                frame_err <= 1'b1;
                err_code  <= code;
                state     <= ST_IDLE;
                fc        <= '0;
                got       <= 1'b0;
                pend      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        fc <= '0;
                        if (fe) begin
                            fc        <= FC_W'(1);
                            state     <= ST_SOF2;
                            pend      <= 1'b1;
                            pend_code <= ERR_SOF;
                        end
                    end
                    ST_SOF2: begin
                        fc <= fc + 1'b1;
                        if (fe) begin
                            fc        <= FC_SOF_NEXT;
                            state     <= ST_DATA;
                            got       <= 1'b0;
                            pend      <= 1'b1;
                            pend_code <= ERR_SOF;
                        end
                    end
                    ST_DATA: begin
                        fc <= fc + 1'b1;
                        if (fe) begin
                            got                  <= 1'b1;
                            shreg[{k, 1'b0} +: 2] <= o[6:5];
                            pend                 <= 1'b1;
                            pend_code            <= ERR_SYM;
                        end
                        if (sym_end) begin
                            got <= 1'b0;
                            if (fc[9:7] == 3'd4) state <= ST_EOF;
                        end
                    end
                    ST_EOF: begin
                        fc <= fc + 1'b1;
                        if (fe) begin
                            got       <= 1'b1;
                            pend      <= 1'b1;
                            pend_code <= ERR_EOF;
                        end
                        if (fc == FC_LAST) begin
                            data_valid <= 1'b1;
                            data_out   <= shreg;
                            state      <= ST_IDLE;
                            fc         <= '0;
                            got        <= 1'b0;
                            pend       <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ppm_decoder.sv
// Directed bench for ppm_decoder: frames are drawn as pulse lists, expected
// strobes (kind, payload, cycle) are queued and matched by a strobe monitor.
module tb_ppm_decoder;
    import ppm_pkg::*;

    localparam int TOL = 4;
    localparam int SS  = 2;
    localparam int LAT = SS + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic [1:0] err_code;

    int cyc    = 0;
    int passed = 0;
    int total  = 0;
    int fails  = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        logic [1:0] code;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   fall[8];
    int   wid[8];
    int   npulse;
    int   n0;

    ppm_decoder #(.TOL(TOL), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Strobe monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && (data_valid || frame_err)) begin
            check("strobe_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_kind", {30'd0, data_valid, frame_err}, e.is_err ? 32'd1 : 32'd2);
                check("strobe_cycle", 32'(cyc), 32'(e.at));
                if (e.is_err) check("err_code", 32'(err_code), 32'(e.code));
                else          check("data_out", 32'(data_out), 32'(e.data));
            end
        end
    end

    task automatic set_clean(input logic [7:0] b, input int sh);
        logic [7:0] bb;
        bb      = b;
        fall[0] = 0;
        fall[1] = SOF_GAP;
        for (int s = 0; s < 4; s++)
            fall[2+s] = DATA_START + s * SYMBOL_CLKS + SLOT_CLKS + 32 * int'(bb[2*s +: 2]) + sh;
        fall[6] = EOF_FALL;
        for (int i = 0; i < 8; i++) wid[i] = SLOT_CLKS;
        npulse = 7;
    endtask

    task automatic drive(input int len);
        for (int c = 0; c < len; c++) begin
            logic lv;
            lv = 1'b1;
            for (int i = 0; i < npulse; i++)
                if (c >= fall[i] && c < fall[i] + wid[i]) lv = 1'b0;
            din = lv;
            @(posedge clk); #1;
        end
        din = 1'b1;
    endtask

    task automatic idle(input int n);
        din = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input bit e, input logic [7:0] d, input logic [1:0] c, input int at);
        exp_t x;
        x.is_err = e; x.data = d; x.code = c; x.at = at;
        sb.push_back(x);
    endtask

    task automatic drain(input string tag);
        idle(12);
        check(tag, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        rst = 1'b0;
        din = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out",   32'(data_out),   32'h00);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_frame_err",  32'(frame_err),  32'd0);
        check("rst_err_code",   32'(err_code),   32'd0);
        rst = 1'b1;
        idle(5);

        // Clean 0xB4 frame.
        set_clean(8'hB4, 0); n0 = cyc;
        push(1'b0, 8'hB4, 2'b00, n0 + LAT + FRAME_END);
        drive(720); drain("clean_b4_done");

        // Symbol pulses late by +3: still inside tolerance.
        set_clean(8'hB4, 3); n0 = cyc;
        push(1'b0, 8'hB4, 2'b00, n0 + LAT + FRAME_END);
        drive(720); drain("shift3_done");

        // +5 leaves the window on symbol 0; stop drawing after it.
        set_clean(8'hB4, 5); npulse = 3; n0 = cyc;
        push(1'b1, 8'h00, 2'b10, n0 + LAT + fall[2] + 1);
        drive(200); drain("shift5_done");
        check("hold_data_after_err", 32'(data_out), 32'hB4);

        // Lone first SOF pulse: timeout 81+TOL cycles after fe.
        set_clean(8'h00, 0); npulse = 1; n0 = cyc;
        push(1'b1, 8'h00, 2'b01, n0 + LAT + SOF_GAP + 1 + TOL);
        drive(120); drain("sof_only_done");

        // Two pulses in symbol 2 at offsets 16 and 80.
        set_clean(8'hB4, 0);
        fall[4] = DATA_START + 2 * SYMBOL_CLKS + 16;
        fall[5] = DATA_START + 2 * SYMBOL_CLKS + 80;
        npulse = 6; n0 = cyc;
        push(1'b1, 8'h00, 2'b10, n0 + LAT + fall[5] + 1);
        drive(500); drain("double_pulse_done");

        set_clean(8'h3C, 0); n0 = cyc;
        push(1'b0, 8'h3C, 2'b00, n0 + LAT + FRAME_END);
        drive(720); drain("clean_3c_done");
        check("hold_err_code", 32'(err_code), 32'd2);

        // Missing EOF pulse.
        set_clean(8'h5A, 0); npulse = 6; n0 = cyc;
        push(1'b1, 8'h00, 2'b11, n0 + LAT + FRAME_END);
        drive(720); drain("no_eof_done");

        // 30-cycle EOF pulse trips the low-time limit at 17+TOL.
        set_clean(8'h5A, 0); wid[6] = 30; n0 = cyc;
        push(1'b1, 8'h00, 2'b11, n0 + LAT + EOF_FALL + SLOT_CLKS + 1 + TOL + 1);
        drive(720); drain("wide_eof_done");
        check("hold_data_wide_eof", 32'(data_out), 32'h3C);

        // Reset during symbol 1, then a clean 0xFF frame.
        set_clean(8'hFF, 0);
        drive(300);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_data_out",   32'(data_out),   32'h00);
        check("midrst_data_valid", 32'(data_valid), 32'd0);
        check("midrst_frame_err",  32'(frame_err),  32'd0);
        check("midrst_err_code",   32'(err_code),   32'd0);
        rst = 1'b1;
        idle(10);
        check("midrst_no_strobe", 32'(sb.size()), 32'd0);

        set_clean(8'hFF, 0); n0 = cyc;
        push(1'b0, 8'hFF, 2'b00, n0 + LAT + FRAME_END);
        drive(720); drain("clean_ff_done");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
